// File: rtl/brightness_scheduler_if.sv
// Bus bundle between the brightness scheduler and its loader, systolic array
// and output RAM. The scheduler side uses the master modport.
interface brightness_scheduler_if #(
   parameter int RAM_ADDR_WIDTH = 6,
   parameter int RAM_DATA_WIDTH = 8,
   parameter int PE_DATA_WIDTH  = 16,
   parameter int LANES          = 4
);
   logic                             start;
   logic [PE_DATA_WIDTH-1:0]         brightness;
   logic                             loader_start;
   logic [PE_DATA_WIDTH*LANES-1:0]   loader_data;
   logic                             loader_valid;
   logic [PE_DATA_WIDTH*LANES-1:0]   pe_data;
   logic [LANES-1:0]                 pe_valid;
   logic [PE_DATA_WIDTH-1:0]         pe_offset;
   logic [PE_DATA_WIDTH*LANES-1:0]   pe_result;
   logic                             pe_result_valid;
   logic                             wr_en;
   logic [RAM_ADDR_WIDTH-1:0]        wr_addr;
   logic [RAM_DATA_WIDTH-1:0]        wr_data;
   logic                             busy;
   logic                             done;
   logic                             error;

   modport master (
      input  start, brightness, loader_data, loader_valid, pe_result, pe_result_valid,
      output loader_start, pe_data, pe_valid, pe_offset,
             wr_en, wr_addr, wr_data, busy, done, error
   );

   modport slave (
      output start, brightness, loader_data, loader_valid, pe_result, pe_result_valid,
      input  loader_start, pe_data, pe_valid, pe_offset,
             wr_en, wr_addr, wr_data, busy, done, error
   );
endinterface

// File: rtl/brightness_scheduler.sv
// Full-frame brightness pass sequencer: starts the loader, skews loader blocks
// into the systolic array, then saturates array results and writes them back
// one pixel per cycle.
module brightness_scheduler #(
   parameter int RAM_ADDR_WIDTH = 6,
   parameter int RAM_DATA_WIDTH = 8,
   parameter int PE_DATA_WIDTH  = 16,
   parameter int LANES          = 4
) (
   input logic                    clk,
   input logic                    reset,
   brightness_scheduler_if.master bus
);
   localparam int BLK_W = PE_DATA_WIDTH * LANES;
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t                    state;

   // input queue (2 blocks); an empty queue passes a pushed block straight through
   logic [BLK_W-1:0]          in_mem [2];
   logic                      in_rd;
   logic                      in_wr;
   logic [1:0]                in_cnt;

   // result queue (2 blocks); the head stays resident until its last lane is written
   logic [BLK_W-1:0]          res_mem [2];
   logic                      res_rd;
   logic                      res_wr;
   logic [1:0]                res_cnt;

   logic [LW-1:0]             lane;
   logic [RAM_ADDR_WIDTH-1:0] base;

   logic                      run;
   logic                      in_push;
   logic                      in_pop;
   logic                      in_issue;
   logic                      in_drop;
   logic                      in_store;
   logic [BLK_W-1:0]          in_head;
   logic                      res_push;
   logic                      res_avail;
   logic                      res_pop;
   logic                      res_drop;
   logic                      res_store;
   logic [BLK_W-1:0]          res_head;
   logic [PE_DATA_WIDTH-1:0]  res_word;
   logic [RAM_DATA_WIDTH-1:0] sat_data;
   logic                      last_write;

   // queue control, writer lane selection and saturation
   always_comb begin
      run        = (state == RUN);

      in_push    = run && bus.loader_valid;
      in_pop     = run && (in_cnt != 2'd0);
      in_issue   = in_pop || in_push;
      in_head    = (in_cnt == 2'd0) ? bus.loader_data : in_mem[in_rd];
      in_drop    = in_push && (in_cnt == 2'd2) && !in_pop;
      in_store   = in_push && !in_drop && (in_cnt != 2'd0);

      res_push   = run && bus.pe_result_valid;
      res_avail  = run && ((res_cnt != 2'd0) || res_push);
      res_head   = (res_cnt == 2'd0) ? bus.pe_result : res_mem[res_rd];
      res_pop    = run && (res_cnt != 2'd0) && (lane == LW'(LANES - 1));
      res_drop   = res_push && (res_cnt == 2'd2) && !res_pop;
      res_store  = res_push && !res_drop;

      res_word   = res_head[lane*PE_DATA_WIDTH +: PE_DATA_WIDTH];
      if (res_word[PE_DATA_WIDTH-1])
         sat_data = '0;
      else if (|res_word[PE_DATA_WIDTH-2:RAM_DATA_WIDTH])
         sat_data = '1;
      else
         sat_data = res_word[RAM_DATA_WIDTH-1:0];

      last_write = bus.wr_en && (bus.wr_addr == '1);
   end

   // control FSM, queues and the registered write port
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         bus.loader_start <= 1'b0;
         bus.pe_offset    <= '0;
         bus.wr_en        <= 1'b0;
         bus.wr_addr      <= '0;
         bus.wr_data      <= '0;
         bus.busy         <= 1'b0;
         bus.done         <= 1'b0;
         bus.error        <= 1'b0;
         in_rd            <= 1'b0;
         in_wr            <= 1'b0;
         in_cnt           <= 2'd0;
         res_rd           <= 1'b0;
         res_wr           <= 1'b0;
         res_cnt          <= 2'd0;
         lane             <= '0;
         base             <= '0;
      end else begin
         bus.loader_start <= 1'b0;

         if (in_store) begin
            in_mem[in_wr] <= bus.loader_data;
            in_wr         <= ~in_wr;
         end
         if (in_pop)
            in_rd <= ~in_rd;
         in_cnt <= in_cnt + 2'(in_store) - 2'(in_pop);

         if (res_store) begin
            res_mem[res_wr] <= bus.pe_result;
            res_wr          <= ~res_wr;
         end
         if (res_pop)
            res_rd <= ~res_rd;
         res_cnt <= res_cnt + 2'(res_store) - 2'(res_pop);

         if (in_drop || res_drop)
            bus.error <= 1'b1;

         if (res_avail) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= base | RAM_ADDR_WIDTH'(lane);
            bus.wr_data <= sat_data;
            if (lane == LW'(LANES - 1)) begin
               lane <= '0;
               base <= base + RAM_ADDR_WIDTH'(LANES);
            end else begin
               lane <= lane + 1'b1;
            end
         end else begin
            bus.wr_en <= 1'b0;
         end

         // placed last so the start-of-pass clears override the queue updates above
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state            <= RUN;
                  bus.pe_offset    <= bus.brightness;
                  bus.loader_start <= 1'b1;
                  bus.busy         <= 1'b1;
                  bus.done         <= 1'b0;
                  bus.error        <= 1'b0;
                  in_rd            <= 1'b0;
                  in_wr            <= 1'b0;
                  in_cnt           <= 2'd0;
                  res_rd           <= 1'b0;
                  res_wr           <= 1'b0;
                  res_cnt          <= 2'd0;
                  lane             <= '0;
                  base             <= '0;
               end
            end
            RUN: begin
               if (last_write)
                  state <= FINISH;
            end
            FINISH: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
               bus.done <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // per-lane skew line: lane g is delayed g extra cycles behind lane 0
   for (genvar g = 0; g < LANES; g++) begin : g_skew
      logic [g:0][PE_DATA_WIDTH-1:0] sd;
      logic [g:0]                    sv;

      if (g == 0) begin : g_first
         // lane 0 registers the issued word directly
         always_ff @(posedge clk) begin
            if (reset) begin
               sd <= '0;
               sv <= '0;
            end else begin
               sd[0] <= in_head[0 +: PE_DATA_WIDTH];
               sv[0] <= in_issue;
            end
         end
      end else begin : g_rest
         // later lanes shift the issued word through g additional stages
         always_ff @(posedge clk) begin
            if (reset) begin
               sd <= '0;
               sv <= '0;
            end else begin
               sd <= {sd[g-1:0], in_head[g*PE_DATA_WIDTH +: PE_DATA_WIDTH]};
               sv <= {sv[g-1:0], in_issue};
            end
         end
      end

      assign bus.pe_data[g*PE_DATA_WIDTH +: PE_DATA_WIDTH] = sd[g];
      assign bus.pe_valid[g]                               = sv[g];
   end
endmodule

// File: tb/tb_brightness_scheduler.sv
// Self-checking bench for brightness_scheduler: behavioural loader/array
// environment, write monitor and a pixel-level reference model.
module tb_brightness_scheduler;
   logic clk;
   logic reset;

   brightness_scheduler_if #(
      .RAM_ADDR_WIDTH(6), .RAM_DATA_WIDTH(8), .PE_DATA_WIDTH(16), .LANES(4)
   ) bus ();

   brightness_scheduler #(
      .RAM_ADDR_WIDTH(6), .RAM_DATA_WIDTH(8), .PE_DATA_WIDTH(16), .LANES(4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   bit          echo_en = 1'b0;
   bit          man_valid = 1'b0;
   logic [63:0] man_data = '0;
   logic [15:0] lq [4][$];
   logic [7:0]  got [64];
   logic [5:0]  order [$];
   int unsigned wr_seen = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat8(input int v);
      if (v < 0) return 0;
      if (v > 255) return 255;
      return v;
   endfunction

   function automatic int word_at(input logic [63:0] b, input int i);
      logic signed [15:0] t;
      t = b[i*16 +: 16];
      return int'(t);
   endfunction

   function automatic logic [63:0] rand_blk();
      logic [63:0] b;
      for (int i = 0; i < 4; i++) b[i*16 +: 16] = 16'($urandom_range(0, 2000) - 1000);
      return b;
   endfunction

   // array stand-in: regroups skewed lanes into a block and echoes word+offset
   initial begin : array_echo
      logic [63:0] eb;
      bit          ev;
      bus.pe_result_valid = 1'b0;
      bus.pe_result       = '0;
      forever begin
         @(posedge clk);
         #2;
         ev = 1'b0;
         eb = '0;
         if (reset) begin
            for (int i = 0; i < 4; i++) lq[i].delete();
         end else if (echo_en) begin
            for (int i = 0; i < 4; i++)
               if (bus.pe_valid[i]) lq[i].push_back(bus.pe_data[i*16 +: 16]);
            if (bus.pe_valid[3]) begin
               ev = 1'b1;
               for (int i = 0; i < 4; i++)
                  if (lq[i].size() > 0) eb[i*16 +: 16] = lq[i].pop_front() + bus.pe_offset;
            end
         end
         bus.pe_result_valid = ev | man_valid;
         bus.pe_result       = ev ? eb : man_data;
      end
   end

   // output RAM stand-in
   always @(negedge clk) begin
      if (bus.wr_en === 1'b1) begin
         got[bus.wr_addr] = bus.wr_data;
         order.push_back(bus.wr_addr);
         wr_seen++;
      end
   end

   task automatic clear_mon();
      wr_seen = 0;
      order.delete();
      for (int n = 0; n < 64; n++) got[n] = 'x;
   endtask

   task automatic do_start(input logic [15:0] br);
      clear_mon();
      bus.brightness = br;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("start_busy", bus.busy, 1);
      check("start_ldpulse", bus.loader_start, 1);
      check("start_offset", bus.pe_offset, br);
      check("start_done_clr", bus.done, 0);
      check("start_err_clr", bus.error, 0);
      tick();
      check("ldpulse_end", bus.loader_start, 0);
   endtask

   task automatic load_block(input logic [63:0] b);
      bus.loader_data  = b;
      bus.loader_valid = 1'b1;
      tick();
      bus.loader_valid = 1'b0;
   endtask

   task automatic wait_write(input int addr, input string tag);
      bit hit = 1'b0;
      for (int c = 0; c < 400 && !hit; c++) begin
         tick();
         if (bus.wr_en === 1'b1 && bus.wr_addr === 6'(addr)) hit = 1'b1;
      end
      check(tag, hit, 1);
   endtask

   task automatic finish_checks(input logic exp_err);
      wait_write(63, "last_write_seen");
      tick();
      check("finish_busy", bus.busy, 1);
      check("finish_done", bus.done, 0);
      tick();
      check("idle_done", bus.done, 1);
      check("idle_busy", bus.busy, 0);
      check("idle_error", bus.error, exp_err);
      check("write_count", wr_seen, 64);
   endtask

   task automatic run_pass(input logic signed [15:0] br, input bit ramp);
      logic [63:0] b;
      int          w;
      int          exp_v [64];
      do_start(br);
      echo_en = 1'b1;
      for (int k = 0; k < 16; k++) begin
         for (int i = 0; i < 4; i++) begin
            w = ramp ? (4*k + i) : (int'($urandom_range(0, 2000)) - 1000);
            b[i*16 +: 16] = 16'(w);
            exp_v[4*k + i] = sat8(w + int'(br));
         end
         load_block(b);
         repeat (3 + $urandom_range(0, 2)) tick();
      end
      finish_checks(1'b0);
      check("first_addr", (order.size() > 0) ? order[0] : 6'h3f, 0);
      for (int n = 0; n < 64; n++) begin
         if (n < order.size()) check("wr_order", order[n], n);
         check(ramp ? "ramp_pixel" : "rand_pixel", got[n], exp_v[n]);
      end
   endtask

   initial begin : main
      logic [63:0] sent [$];
      logic [63:0] acc  [$];
      bit          wr_after_rst;

      reset = 1'b1;
      bus.start = 1'b0;
      bus.brightness = '0;
      bus.loader_valid = 1'b0;
      bus.loader_data = '0;
      repeat (3) tick();
      check("rst_loader_start", bus.loader_start, 0);
      check("rst_pe_valid", bus.pe_valid, 0);
      check("rst_pe_data", bus.pe_data, 0);
      check("rst_pe_offset", bus.pe_offset, 0);
      check("rst_wr_en", bus.wr_en, 0);
      check("rst_wr_addr", bus.wr_addr, 0);
      check("rst_wr_data", bus.wr_data, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_error", bus.error, 0);
      reset = 1'b0;
      tick();

      // pass A: manual results: saturation, ignored start, overflow
      do_start(16'd5);
      man_data = {16'h0123, 16'h00FF, 16'h0000, 16'hFFF6};
      sent.push_back(man_data);
      man_valid = 1'b1;
      tick();
      man_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("sat_wr_en", bus.wr_en, 1);
         check("sat_wr_addr", bus.wr_addr, i);
         check("sat_wr_data", bus.wr_data, (i < 2) ? 8'h00 : 8'hFF);
         tick();
      end
      check("sat_wr_stop", bus.wr_en, 0);

      bus.brightness = 16'h7777;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("restart_no_pulse", bus.loader_start, 0);
      check("restart_offset", bus.pe_offset, 16'd5);
      check("restart_busy", bus.busy, 1);

      man_valid = 1'b1;
      for (int j = 0; j < 3; j++) begin
         man_data = rand_blk();
         sent.push_back(man_data);
         tick();
      end
      man_valid = 1'b0;
      check("ovf_error_set", bus.error, 1);
      repeat (8) tick();
      check("ovf_error_sticky", bus.error, 1);
      for (int j = 0; j < 13; j++) begin
         man_data = rand_blk();
         sent.push_back(man_data);
         man_valid = 1'b1;
         tick();
         man_valid = 1'b0;
         if (j < 12) repeat (3) tick();
      end
      finish_checks(1'b1);
      // the third block of the burst arrives with two blocks resident and no pop
      for (int j = 0; j < sent.size(); j++) if (j != 3) acc.push_back(sent[j]);
      for (int n = 0; n < 64; n++)
         check("ovf_pixel", got[n], sat8(word_at(acc[n/4], n%4)));

      // pass B: ramp with +10
      run_pass(16'sd10, 1'b1);

      // pass D: skew timing, then reset during the fifth write
      do_start(16'd3);
      echo_en = 1'b1;
      load_block({16'd4, 16'd3, 16'd2, 16'd1});
      for (int i = 0; i < 4; i++) begin
         check("skew_valid", bus.pe_valid, 4'b0001 << i);
         check("skew_word", bus.pe_data[i*16 +: 16], i + 1);
         tick();
      end
      check("skew_idle", bus.pe_valid, 0);
      load_block({16'd8, 16'd7, 16'd6, 16'd5});
      wait_write(4, "fifth_write_seen");
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mrst_wr_en", bus.wr_en, 0);
      check("mrst_busy", bus.busy, 0);
      check("mrst_done", bus.done, 0);
      check("mrst_error", bus.error, 0);
      check("mrst_pe_valid", bus.pe_valid, 0);
      check("mrst_pe_offset", bus.pe_offset, 0);
      check("mrst_wr_addr", bus.wr_addr, 0);
      wr_after_rst = 1'b0;
      repeat (4) begin
         tick();
         if (bus.wr_en !== 1'b0) wr_after_rst = 1'b1;
      end
      check("mrst_no_writes", wr_after_rst, 0);

      // pass C: random words and offset, fresh pass from address 0
      run_pass(16'(int'($urandom_range(0, 600)) - 300), 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
